prog_sequencer: RTL and testbench

Parametrised program sequencer for the processor core. It owns the program counter, the run/done handshake and a writable jump-target table. It supports relative and absolute branches, a stall hold, an explicit halt and a configurable halt address. It replaces the fixed-width PC plus hard-wired target lookup, and sits between the control decoder (branch/halt/stall requests) and the instruction ROM (drives `prog_ctr`).

---
 rtl/prog_seq_pkg.sv | 21 ++
 rtl/prog_sequencer_jump_lut.sv | 32 +++
 rtl/prog_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_prog_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg: shared state encoding, default sizes and a width helper
// for the program sequencer and its jump table.
package prog_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int DEF_D         = 12;
  localparam int DEF_LUT_N     = 4;
  localparam int DEF_HALT_ADDR = 128;
  localparam int DEF_RS_DEPTH  = 4;

  // Index width for an n-entry table; a single-entry table still gets one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_sequencer_jump_lut.sv
// jump_lut: LUT_N x D register file holding branch/call targets.
// One synchronous write port, one combinational read port, async clear.
// A write and a read of the same entry in one cycle returns the old value.
module jump_lut #(
  parameter int D     = 12,
  parameter int LUT_N = 4,
  parameter int LUT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [LUT_W-1:0] i_wr_addr,
  input  logic [D-1:0]     i_wr_data,
  input  logic [LUT_W-1:0] i_rd_addr,
  output logic [D-1:0]     o_rd_data
);

  logic [D-1:0] r_mem [LUT_N];

  // Table storage: cleared asynchronously, written on the strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LUT_N; i++) r_mem[i] <= '0;
    end else if (i_wr_en && (int'(i_wr_addr) < LUT_N)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Out-of-range selects (non power-of-two LUT_N) read as zero.
  assign o_rd_data = (int'(i_rd_addr) < LUT_N) ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: program counter, run/done handshake and jump table.
// Optional return stack is built when PROG_SEQ_RSTACK_EN is defined;
// otherwise call/ret are ignored and fault is tied low.
//
// Handshake: req is a level sampled on the rising edge. In IDLE or DONE a
// sampled req starts a program (PC 0, running 1 after that edge); in RUN
// req is ignored. done stays high until the next accepted req.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int D         = DEF_D,
  parameter int LUT_N     = DEF_LUT_N,
  parameter int LUT_W     = clog2_min1(LUT_N),
  parameter int HALT_ADDR = DEF_HALT_ADDR,
  parameter int RS_DEPTH  = DEF_RS_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             stall,
  input  logic             branch,
  input  logic             reljump_en,
  input  logic [LUT_W-1:0] lut_sel,
  input  logic             lut_wr_en,
  input  logic [LUT_W-1:0] lut_wr_addr,
  input  logic [D-1:0]     lut_wr_data,
  input  logic             halt,
  input  logic             call,
  input  logic             ret,
  output logic [D-1:0]     prog_ctr,
  output logic             running,
  output logic             done,
  output logic             fault,
  output seq_state_t       dbg_state
);

  localparam logic [D-1:0] HALT_PC = D'(HALT_ADDR);

  seq_state_t   r_state;
  logic [D-1:0] r_pc;
  logic         r_running;
  logic         r_done;
  logic [D-1:0] w_lut_data;
  logic [D-1:0] w_next_pc;

  jump_lut #(
    .D     (D),
    .LUT_N (LUT_N),
    .LUT_W (LUT_W)
  ) u_lut (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (lut_wr_en),
    .i_wr_addr (lut_wr_addr),
    .i_wr_data (lut_wr_data),
    .i_rd_addr (lut_sel),
    .o_rd_data (w_lut_data)
  );

`ifdef PROG_SEQ_RSTACK_EN
  localparam int SP_W  = $clog2(RS_DEPTH + 1);
  localparam int IDX_W = clog2_min1(RS_DEPTH);

  logic [D-1:0]     r_stack [RS_DEPTH];
  logic [SP_W-1:0]  r_sp;
  logic             r_fault;
  logic [IDX_W-1:0] w_top_idx;
  logic             w_push;
  logic             w_pop;
  logic             w_rs_fault;

  assign w_top_idx = IDX_W'(r_sp - SP_W'(1));
  assign fault     = r_fault;
`else
  logic w_unused;
  assign w_unused = call ^ ret ^ (RS_DEPTH > 0);
  assign fault    = 1'b0;
`endif

  // Next-PC selection for a RUN cycle: ret, call, branch, then increment.
  always_comb begin
    w_next_pc = r_pc + D'(1);
`ifdef PROG_SEQ_RSTACK_EN
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_rs_fault = 1'b0;
    if (ret) begin
      if (r_sp == '0) begin
        w_rs_fault = 1'b1;
      end else begin
        w_pop     = 1'b1;
        w_next_pc = r_stack[w_top_idx];
      end
    end else if (call) begin
      if (r_sp == SP_W'(RS_DEPTH)) begin
        w_rs_fault = 1'b1;
      end else begin
        w_push    = 1'b1;
        w_next_pc = w_lut_data;
      end
    end else
`endif
    if (branch) begin
      // Relative offset is a signed D-bit value; D-bit addition wraps.
      w_next_pc = reljump_en ? (r_pc + w_lut_data) : w_lut_data;
    end
  end

  // Sequencer FSM with registered PC, running, done (and fault/stack).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
`ifdef PROG_SEQ_RSTACK_EN
      r_fault   <= 1'b0;
      r_sp      <= '0;
      for (int i = 0; i < RS_DEPTH; i++) r_stack[i] <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req) begin
            r_state   <= RUN;
            r_running <= 1'b1;
            r_pc      <= '0;
`ifdef PROG_SEQ_RSTACK_EN
            r_sp      <= '0;
`endif
          end
        end
        RUN: begin
          if (!stall) begin
            if (halt) begin
              r_state   <= DONE;
              r_running <= 1'b0;
              r_done    <= 1'b1;
            end
`ifdef PROG_SEQ_RSTACK_EN
            else if (w_rs_fault) begin
              r_state   <= DONE;
              r_running <= 1'b0;
              r_done    <= 1'b1;
              r_fault   <= 1'b1;
            end
`endif
            else begin
              r_pc <= w_next_pc;
              if (w_next_pc == HALT_PC) begin
                r_state   <= DONE;
                r_running <= 1'b0;
                r_done    <= 1'b1;
              end
`ifdef PROG_SEQ_RSTACK_EN
              if (w_push) begin
                r_stack[IDX_W'(r_sp)] <= r_pc + D'(1);
                r_sp                  <= r_sp + SP_W'(1);
              end
              if (w_pop) begin
                r_sp <= r_sp - SP_W'(1);
              end
`endif
            end
          end
        end
        DONE: begin
          if (req) begin
            r_state   <= RUN;
            r_running <= 1'b1;
            r_done    <= 1'b0;
            r_pc      <= '0;
`ifdef PROG_SEQ_RSTACK_EN
            r_fault   <= 1'b0;
            r_sp      <= '0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign prog_ctr  = r_pc;
  assign running   = r_running;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: scenario tasks drive one cycle at a time; expected
// {fault, done, running, prog_ctr} is queued at drive time and compared
// one time unit after the following rising edge.
module tb_prog_sequencer;
  import prog_seq_pkg::*;

  logic        clk;
  logic        reset;
  logic        req, stall, branch, reljump_en, halt, call, ret;
  logic [1:0]  lut_sel;
  logic        lut_wr_en;
  logic [1:0]  lut_wr_addr;
  logic [11:0] lut_wr_data;
  logic [11:0] prog_ctr;
  logic        running, done, fault;
  seq_state_t  dbg_state;

  typedef struct packed {
    logic        req, stall, halt, branch, rel, call, ret;
    logic [1:0]  sel;
    logic        wr;
    logic [1:0]  wa;
    logic [11:0] wd;
  } stim_t;

  logic [14:0] exp_q[$];
  logic [14:0] got, exp_v;
  int          n_checks = 0;
  int          n_fail   = 0;

  prog_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .stall       (stall),
    .branch      (branch),
    .reljump_en  (reljump_en),
    .lut_sel     (lut_sel),
    .lut_wr_en   (lut_wr_en),
    .lut_wr_addr (lut_wr_addr),
    .lut_wr_data (lut_wr_data),
    .halt        (halt),
    .call        (call),
    .ret         (ret),
    .prog_ctr    (prog_ctr),
    .running     (running),
    .done        (done),
    .fault       (fault),
    .dbg_state   (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] pk(input logic f, input logic d, input logic r,
                                     input logic [11:0] pc);
    return {f, d, r, pc};
  endfunction

  // Argument order: req stall halt branch rel call ret sel wr wa wd
  function automatic stim_t st(input logic rq, input logic sl, input logic hl,
                               input logic br, input logic rl, input logic cl,
                               input logic rt, input logic [1:0] sel,
                               input logic wr, input logic [1:0] wa,
                               input logic [11:0] wd);
    stim_t s;
    s = {rq, sl, hl, br, rl, cl, rt, sel, wr, wa, wd};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    req = s.req; stall = s.stall; halt = s.halt; branch = s.branch;
    reljump_en = s.rel; call = s.call; ret = s.ret; lut_sel = s.sel;
    lut_wr_en = s.wr; lut_wr_addr = s.wa; lut_wr_data = s.wd;
  endtask

  task automatic test_reset();
    apply('0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(pk(0, 0, 0, 12'd0));
    got = {fault, done, running, prog_ctr}; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", got, exp_v);
    end
    // Branch and halt in IDLE must not move anything.
    @(negedge clk);
    reset = 1'b0;
    apply(st(0, 0, 1, 1, 0, 0, 0, 2'd0, 0, 2'd0, 12'd0));
    exp_q.push_back(pk(0, 0, 0, 12'd0));
    @(posedge clk); #1;
    got = {fault, done, running, prog_ctr}; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL idle_hold: got %h expected %h", got, exp_v);
    end
  endtask

  // Start, then free-run with random stalls and stray req until HALT_ADDR.
  task automatic test_count();
    stim_t s;
    logic [11:0] m_pc;
    int cyc;
    m_pc = 12'd0;
    cyc = 0;
    s = st(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 12'd0);
    while (cyc < 400) begin
      @(negedge clk);
      apply(s);
      if (cyc == 0) m_pc = 12'd0;
      else if (!s.stall) m_pc = m_pc + 12'd1;
      exp_q.push_back(pk(0, m_pc == 12'd128, m_pc != 12'd128, m_pc));
      @(posedge clk); #1;
      got = {fault, done, running, prog_ctr}; exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL count[%0d]: got %h expected %h", cyc, got, exp_v);
      end
      cyc++;
      if (m_pc == 12'd128) break;
      s = st(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), 0, 0, 0, 0, 0,
             2'd0, 0, 2'd0, 12'd0);
    end
    if (cyc >= 400) begin
      n_checks++; n_fail++;
      $display("FAIL count_timeout: got pc %0d expected 128", prog_ctr);
    end
    // DONE holds the PC.
    @(negedge clk);
    apply('0);
    exp_q.push_back(pk(0, 1, 0, 12'd128));
    @(posedge clk); #1;
    got = {fault, done, running, prog_ctr}; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL done_hold: got %h expected %h", got, exp_v);
    end
  endtask

  // Restart from DONE, load table, absolute then relative (wrapping) branch,
  // stall over halt, and halt over branch.
  task automatic test_branch_stall();
    stim_t sq[$];
    sq.push_back(st(1, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 12'd40));  exp_q.push_back(pk(0, 0, 1, 12'd0));
    sq.push_back(st(0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 12'hFFD)); exp_q.push_back(pk(0, 0, 1, 12'd1));
    for (int k = 2; k <= 5; k++) begin
      sq.push_back('0); exp_q.push_back(pk(0, 0, 1, 12'(k)));
    end
    sq.push_back(st(0, 0, 0, 1, 0, 0, 0, 2'd1, 0, 2'd0, 12'd0));   exp_q.push_back(pk(0, 0, 1, 12'd40));
    sq.push_back(st(0, 0, 0, 1, 1, 0, 0, 2'd2, 0, 2'd0, 12'd0));   exp_q.push_back(pk(0, 0, 1, 12'd37));
    sq.push_back(st(0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 12'd10));  exp_q.push_back(pk(0, 0, 1, 12'd38));
    sq.push_back(st(0, 0, 0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 12'd0));   exp_q.push_back(pk(0, 0, 1, 12'd10));
    sq.push_back(st(0, 1, 1, 1, 0, 0, 0, 2'd1, 0, 2'd0, 12'd0));   exp_q.push_back(pk(0, 0, 1, 12'd10));
    sq.push_back(st(0, 0, 1, 1, 0, 0, 0, 2'd1, 0, 2'd0, 12'd0));   exp_q.push_back(pk(0, 1, 0, 12'd10));
    for (int i = 0; i < sq.size(); i++) begin
      @(negedge clk); apply(sq[i]);
      @(posedge clk); #1;
      got = {fault, done, running, prog_ctr}; exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL branch_stall[%0d]: got %h expected %h", i, got, exp_v);
      end
    end
  endtask

  // Restart, count to 7, reset between edges, then confirm the table cleared.
  task automatic test_restart_reset();
    stim_t sq[$];
    sq.push_back(st(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 12'd0)); exp_q.push_back(pk(0, 0, 1, 12'd0));
    for (int k = 1; k <= 7; k++) begin
      sq.push_back('0); exp_q.push_back(pk(0, 0, 1, 12'(k)));
    end
    for (int i = 0; i < sq.size(); i++) begin
      @(negedge clk); apply(sq[i]);
      @(posedge clk); #1;
      got = {fault, done, running, prog_ctr}; exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL restart[%0d]: got %h expected %h", i, got, exp_v);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(pk(0, 0, 0, 12'd0));
    #2;
    got = {fault, done, running, prog_ctr}; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", got, exp_v);
    end
    @(negedge clk);
    reset = 1'b0;
    sq.delete();
    sq.push_back(st(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 12'd0)); exp_q.push_back(pk(0, 0, 1, 12'd0));
    sq.push_back('0);                                             exp_q.push_back(pk(0, 0, 1, 12'd1));
    sq.push_back(st(0, 0, 0, 1, 0, 0, 0, 2'd1, 0, 2'd0, 12'd0)); exp_q.push_back(pk(0, 0, 1, 12'd0));
    for (int i = 0; i < sq.size(); i++) begin
      @(negedge clk); apply(sq[i]);
      @(posedge clk); #1;
      got = {fault, done, running, prog_ctr}; exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL lut_cleared[%0d]: got %h expected %h", i, got, exp_v);
      end
    end
  endtask

  // Same-cycle write/read returns the old entry; then a branch straight to
  // HALT_ADDR ends the program.
  task automatic test_collision_halt_addr();
    stim_t sq[$];
    sq.push_back(st(0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd3, 12'd20));  exp_q.push_back(pk(0, 0, 1, 12'd1));
    sq.push_back(st(0, 0, 0, 1, 0, 0, 0, 2'd3, 1, 2'd3, 12'd50));  exp_q.push_back(pk(0, 0, 1, 12'd20));
    sq.push_back(st(0, 0, 0, 1, 0, 0, 0, 2'd3, 0, 2'd0, 12'd0));   exp_q.push_back(pk(0, 0, 1, 12'd50));
    sq.push_back(st(0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 12'd128)); exp_q.push_back(pk(0, 0, 1, 12'd51));
    sq.push_back(st(0, 0, 0, 1, 0, 0, 0, 2'd1, 0, 2'd0, 12'd0));   exp_q.push_back(pk(0, 1, 0, 12'd128));
    for (int i = 0; i < sq.size(); i++) begin
      @(negedge clk); apply(sq[i]);
      @(posedge clk); #1;
      got = {fault, done, running, prog_ctr}; exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL collision[%0d]: got %h expected %h", i, got, exp_v);
      end
    end
  endtask

`ifdef PROG_SEQ_RSTACK_EN
  // call/ret round trip, underflow fault, restart, overflow fault.
  task automatic test_stack();
    stim_t sq[$];
    sq.push_back(st(1, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 12'd60));  exp_q.push_back(pk(0, 0, 1, 12'd0));
    for (int k = 1; k <= 4; k++) begin
      sq.push_back('0); exp_q.push_back(pk(0, 0, 1, 12'(k)));
    end
    sq.push_back(st(0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 2'd0, 12'd0));   exp_q.push_back(pk(0, 0, 1, 12'd60));
    sq.push_back(st(0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 12'd0));   exp_q.push_back(pk(0, 0, 1, 12'd5));
    sq.push_back(st(0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 12'd0));   exp_q.push_back(pk(1, 1, 0, 12'd5));
    sq.push_back('0);                                               exp_q.push_back(pk(1, 1, 0, 12'd5));
    sq.push_back(st(1, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 12'd100)); exp_q.push_back(pk(0, 0, 1, 12'd0));
    for (int k = 0; k < 4; k++) begin
      sq.push_back(st(0, 0, 0, 0, 0, 1, 0, 2'd1, 0, 2'd0, 12'd0)); exp_q.push_back(pk(0, 0, 1, 12'd100));
    end
    sq.push_back(st(0, 0, 0, 0, 0, 1, 0, 2'd1, 0, 2'd0, 12'd0));   exp_q.push_back(pk(1, 1, 0, 12'd100));
    for (int i = 0; i < sq.size(); i++) begin
      @(negedge clk); apply(sq[i]);
      @(posedge clk); #1;
      got = {fault, done, running, prog_ctr}; exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL stack[%0d]: got %h expected %h", i, got, exp_v);
      end
    end
  endtask
`else
  // Without the stack, call/ret fall through to a plain increment.
  task automatic test_stack();
    stim_t sq[$];
    sq.push_back(st(1, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 12'd60)); exp_q.push_back(pk(0, 0, 1, 12'd0));
    sq.push_back(st(0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 2'd0, 12'd0));  exp_q.push_back(pk(0, 0, 1, 12'd1));
    sq.push_back(st(0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 12'd0));  exp_q.push_back(pk(0, 0, 1, 12'd2));
    sq.push_back(st(0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 12'd0));  exp_q.push_back(pk(0, 0, 1, 12'd3));
    for (int i = 0; i < sq.size(); i++) begin
      @(negedge clk); apply(sq[i]);
      @(posedge clk); #1;
      got = {fault, done, running, prog_ctr}; exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL no_stack[%0d]: got %h expected %h", i, got, exp_v);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    apply('0);
    test_reset();
    test_count();
    test_branch_stall();
    test_restart_reset();
    test_collision_halt_addr();
    test_stack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
